// File: rtl/matmul_lanes.sv
// matmul_lanes: runtime-sized, lane-parallel signed matrix multiply, Z = X*Y or Z += X*Y.
// Holds its own X/Y/Z storage. The host writes X and Y and reads Z through RAM-style ports.
// Element (r,c) of every matrix lives at host address r*MAX_SIZE+c.
// Y and Z are banked by column mod LANES, so one tile of LANES adjacent Z columns
// can read all of its Y operands, and write all of its results, in the same cycle.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   start/size/accumulate  run request; sampled in IDLE only
//   busy, done, err        run in progress, completion pulse, illegal-start/dropped-write pulse
//   x_wr_*, y_wr_*         host write ports; writes are dropped while busy
//   z_rd_addr, z_dout      host read port, 1-cycle registered, holds its value while busy
//
// state  | meaning
// IDLE   | waiting for start; host ports active
// ISSUE  | n cycles: read X[i][k] and Y[k][j0+l]; first cycle also reads old Z
// DRAIN  | last read data enters the MACs
// WB     | write the tile's results to Z, then step to the next tile
// FIN    | last tile written; done pulses on leaving
module matmul_lanes #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_SIZE   = 8,
   parameter int LANES      = 2
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic [$clog2(MAX_SIZE):0]   size,
   input  logic                        accumulate,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   input  logic                        x_wr_en,
   input  logic [ADDR_WIDTH-1:0]       x_wr_addr,
   input  logic [DATA_WIDTH-1:0]       x_din,
   input  logic                        y_wr_en,
   input  logic [ADDR_WIDTH-1:0]       y_wr_addr,
   input  logic [DATA_WIDTH-1:0]       y_din,
   input  logic [ADDR_WIDTH-1:0]       z_rd_addr,
   output logic [DATA_WIDTH-1:0]       z_dout
);
   localparam int IW     = $clog2(MAX_SIZE) + 1;
   localparam int CELLS  = MAX_SIZE * MAX_SIZE;
   localparam int BANK_D = CELLS / LANES;
   localparam int CW     = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam int BW     = (BANK_D > 1) ? $clog2(BANK_D) : 1;
   localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [ADDR_WIDTH-1:0] LANES_A  = ADDR_WIDTH'(LANES);
   localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(MAX_SIZE);
   localparam logic [ADDR_WIDTH:0]   CELLS_A  = (ADDR_WIDTH + 1)'(CELLS);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WB, S_FIN} state_t;

   function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [IW-1:0] r, input logic [IW-1:0] c);
      return ADDR_WIDTH'(r) * STRIDE_A + ADDR_WIDTH'(c);
   endfunction

   function automatic logic [LW-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] t;
      t = a % LANES_A;
      return t[LW-1:0];
   endfunction

   function automatic logic [BW-1:0] bank_addr(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] t;
      t = a / LANES_A;
      return t[BW-1:0];
   endfunction

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} < CELLS_A;
   endfunction

   logic [DATA_WIDTH-1:0] x_mem [CELLS];
   logic [DATA_WIDTH-1:0] y_mem [LANES][BANK_D];
   logic [DATA_WIDTH-1:0] z_mem [LANES][BANK_D];

   state_t          state_q, state_d;
   logic [IW-1:0]   n_q, n_d, i_q, i_d, j_q, j_d, k_q, k_d;
   logic            accm_q, accm_d;
   logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [DATA_WIDTH-1:0] z_dout_q;

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] x_rd_q;
   logic [DATA_WIDTH-1:0] y_rd_q [LANES];
   logic [DATA_WIDTH-1:0] zold_q [LANES];
   logic [DATA_WIDTH-1:0] acc_q  [LANES];
   logic [DATA_WIDTH-1:0] prod   [LANES];
   logic [DATA_WIDTH-1:0] z_wb   [LANES];

   logic [ADDR_WIDTH-1:0] x_rd_a, y_rd_a, z_t_a;
   logic [BW-1:0]         y_ba, z_ba;
   logic                  legal, x_wr_ok, y_wr_ok;

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign z_dout = z_dout_q;

   // j0 is always a multiple of LANES, so lane l of a tile sits in bank l at the same bank address.
   assign x_rd_a  = cell_addr(i_q, k_q);
   assign y_rd_a  = cell_addr(k_q, j_q);
   assign z_t_a   = cell_addr(i_q, j_q);
   assign y_ba    = bank_addr(y_rd_a);
   assign z_ba    = bank_addr(z_t_a);
   assign x_wr_ok = x_wr_en && !busy_q && in_range(x_wr_addr);
   assign y_wr_ok = y_wr_en && !busy_q && in_range(y_wr_addr);
   assign legal   = (size != '0) && (size <= IW'(MAX_SIZE)) && ((size % IW'(LANES)) == '0);

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         prod[l] = x_rd_q * y_rd_q[l];
         z_wb[l] = accm_q ? (zold_q[l] + acc_q[l]) : acc_q[l];
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      accm_d  = accm_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      err_d   = busy_q && (x_wr_en || y_wr_en);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (legal) begin
                  n_d     = size;
                  accm_d  = accumulate;
                  i_d     = '0;
                  j_d     = '0;
                  k_d     = '0;
                  state_d = S_ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (k_q == n_q - 1'b1) begin
               k_d     = '0;
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_DRAIN: state_d = S_WB;
         S_WB: begin
            if (j_q + IW'(LANES) < n_q) begin
               j_d     = j_q + IW'(LANES);
               state_d = S_ISSUE;
            end else begin
               j_d = '0;
               if (i_q == n_q - 1'b1) begin
                  state_d = S_FIN;
               end else begin
                  i_d     = i_q + 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // FIN still counts as busy; busy drops on the same edge that raises done.
      busy_d = (state_d != S_IDLE);
      done_d = (state_q == S_FIN);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         n_q      <= '0;
         accm_q   <= 1'b0;
         i_q      <= '0;
         j_q      <= '0;
         k_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         z_dout_q <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         accm_q  <= accm_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         if (!busy_q) begin
            z_dout_q <= in_range(z_rd_addr) ? z_mem[bank_of(z_rd_addr)][bank_addr(z_rd_addr)] : '0;
         end
      end
   end

   // Reads are registered: data read in ISSUE cycle k reaches the MACs one cycle later,
   // which is why DRAIN exists and why the accumulators clear on the tile's first ISSUE cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         x_rd_q  <= '0;
         for (int l = 0; l < LANES; l++) begin
            y_rd_q[l] <= '0;
            zold_q[l] <= '0;
            acc_q[l]  <= '0;
         end
      end else begin
         valid_q <= (state_q == S_ISSUE);
         if (state_q == S_ISSUE) begin
            x_rd_q <= x_mem[x_rd_a[CW-1:0]];
            for (int l = 0; l < LANES; l++) begin
               y_rd_q[l] <= y_mem[l][y_ba];
               if (k_q == '0 && accm_q) zold_q[l] <= z_mem[l][z_ba];
            end
         end
         for (int l = 0; l < LANES; l++) begin
            if (state_q == S_ISSUE && k_q == '0) acc_q[l] <= '0;
            else if (valid_q)                   acc_q[l] <= acc_q[l] + prod[l];
         end
      end
   end

   // Storage is deliberately left out of reset so Z keeps partial results across an abort.
   always_ff @(posedge clock) begin
      if (x_wr_ok) x_mem[x_wr_addr[CW-1:0]] <= x_din;
      if (y_wr_ok) y_mem[bank_of(y_wr_addr)][bank_addr(y_wr_addr)] <= y_din;
      if (state_q == S_WB) begin
         for (int l = 0; l < LANES; l++) z_mem[l][z_ba] <= z_wb[l];
      end
   end
endmodule

// File: tb/tb_matmul_lanes.sv
module tb_matmul_lanes;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int MS = 8;
   localparam int LN = 2;

   logic          clock, reset, start, accumulate, busy, done, err;
   logic [3:0]    size;
   logic          x_wr_en, y_wr_en;
   logic [AW-1:0] x_wr_addr, y_wr_addr, z_rd_addr;
   logic [DW-1:0] x_din, y_din, z_dout;

   int checks = 0;
   int errors = 0;

   logic [31:0] xm [64];
   logic [31:0] ym [64];
   logic [31:0] zm [64];
   logic [31:0] exp_q [$];

   matmul_lanes #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_SIZE(MS), .LANES(LN)) dut (
      .clock(clock), .reset(reset), .start(start), .size(size), .accumulate(accumulate),
      .busy(busy), .done(done), .err(err),
      .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_din(x_din),
      .y_wr_en(y_wr_en), .y_wr_addr(y_wr_addr), .y_din(y_din),
      .z_rd_addr(z_rd_addr), .z_dout(z_dout)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_x(input int a, input logic [31:0] v);
      x_wr_en = 1'b1; x_wr_addr = AW'(a); x_din = v;
      tick();
      x_wr_en = 1'b0;
      xm[a] = v;
   endtask

   task automatic write_y(input int a, input logic [31:0] v);
      y_wr_en = 1'b1; y_wr_addr = AW'(a); y_din = v;
      tick();
      y_wr_en = 1'b0;
      ym[a] = v;
   endtask

   task automatic update_model(input int n, input bit acc);
      logic [31:0] sum;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < n; j++) begin
            sum = acc ? zm[i*MS+j] : 32'd0;
            for (int k = 0; k < n; k++) sum = sum + xm[i*MS+k] * ym[k*MS+j];
            zm[i*MS+j] = sum;
         end
      end
   endtask

   task automatic check_z(input string tag);
      logic [31:0] exp_v;
      for (int a = 0; a < 64; a++) begin
         exp_q.push_back(zm[a]);
         z_rd_addr = AW'(a);
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if (z_dout !== exp_v) begin
            errors++;
            $display("FAIL %s z[%0d]: got %h expected %h", tag, a, z_dout, exp_v);
         end
      end
   endtask

   task automatic run_mat(input int n, input bit acc, input bit poke, input bit co_wr,
                          input int co_addr, input logic [31:0] co_val, input string tag);
      int cnt, expect_cyc;
      bit busy_ok, seen;
      expect_cyc = 1 + (n * n / LN) * (n + 2);
      start = 1'b1; size = 4'(n); accumulate = acc;
      if (co_wr) begin
         x_wr_en = 1'b1; x_wr_addr = AW'(co_addr); x_din = co_val;
         xm[co_addr] = co_val;
      end
      tick();
      start = 1'b0; x_wr_en = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_accept: got %b expected 1", tag, busy); end
      update_model(n, acc);
      cnt = 0; busy_ok = 1'b1; seen = 1'b0;
      while (!seen && cnt < expect_cyc + 20) begin
         x_wr_en = poke && (cnt == 2);
         x_wr_addr = '0; x_din = 32'd5;
         tick();
         cnt++;
         x_wr_en = 1'b0;
         if (poke && cnt == 3) begin
            checks++;
            if (err !== 1'b1) begin errors++; $display("FAIL %s err_on_dropped_write: got %b expected 1", tag, err); end
         end
         if (done === 1'b1) seen = 1'b1;
         else if (busy !== 1'b1) busy_ok = 1'b0;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s done_timeout: got no done after %0d cycles expected %0d", tag, cnt, expect_cyc);
      end else begin
         checks++;
         if (cnt != expect_cyc) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, cnt, expect_cyc); end
         if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b expected 0", tag, busy); end
      end
      checks++;
      if (!busy_ok) begin errors++; $display("FAIL %s busy_during_run: got 0 expected 1", tag); end
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse_width: got %b expected 0", tag, done); end
   endtask

   task automatic load_identity();
      for (int a = 0; a < 64; a++) begin
         write_x(a, (a / MS == a % MS) ? 32'd1 : 32'd0);
         write_y(a, 32'(a));
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; size = '0; accumulate = 1'b0;
      x_wr_en = 1'b0; y_wr_en = 1'b0; x_wr_addr = '0; y_wr_addr = '0;
      x_din = '0; y_din = '0; z_rd_addr = '0;
      #12;
      checks++;
      if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, err}); end
      checks++;
      if (z_dout !== 32'd0) begin errors++; $display("FAIL reset_z_dout: got %h expected 0", z_dout); end
      @(posedge clock); #1 reset = 1'b1;
      tick();
   endtask

   task automatic test_identity();
      load_identity();
      run_mat(8, 1'b0, 1'b0, 1'b0, 0, 0, "identity");
      check_z("identity");
   endtask

   task automatic test_partial_tile();
      for (int a = 0; a < 64; a++) begin
         write_x(a, (a % MS == 0) ? 32'd1 : 32'd0);
         write_y(a, (a / MS == 0) ? 32'hDEADBEEF : 32'd0);
      end
      run_mat(8, 1'b0, 1'b0, 1'b0, 0, 0, "preload");
      for (int a = 0; a < 64; a++) begin
         write_x(a, 32'd2);
         write_y(a, 32'd3);
      end
      run_mat(4, 1'b0, 1'b0, 1'b0, 0, 0, "n4");
      check_z("n4");
   endtask

   task automatic test_accumulate();
      run_mat(4, 1'b1, 1'b0, 1'b0, 0, 0, "accum");
      check_z("accum");
   endtask

   task automatic test_illegal();
      int sizes [3];
      sizes = '{3, 0, 9};
      for (int t = 0; t < 3; t++) begin
         start = 1'b1; size = 4'(sizes[t]);
         tick();
         start = 1'b0;
         checks++;
         if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL illegal_err size=%0d: got err=%b busy=%b expected err=1 busy=0", sizes[t], err, busy);
         end
         tick();
         checks++;
         if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL illegal_after size=%0d: got err=%b done=%b busy=%b expected 000", sizes[t], err, done, busy);
         end
      end
      check_z("illegal");
   endtask

   task automatic test_wrap_and_drop();
      for (int a = 0; a < 64; a++) begin
         write_x(a, 32'h7FFFFFFF);
         write_y(a, 32'd2);
      end
      run_mat(2, 1'b0, 1'b1, 1'b0, 0, 0, "wrap");
      check_z("wrap");
      // start together with a write of X[1][1]; the run must see the new value
      run_mat(2, 1'b0, 1'b0, 1'b1, 9, 32'd1, "co_write");
      check_z("co_write");
   endtask

   task automatic test_reset_mid_run();
      load_identity();
      start = 1'b1; size = 4'd8; accumulate = 1'b0;
      tick();
      start = 1'b0;
      repeat (50) tick();
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({busy, done, z_dout} !== {2'b00, 32'd0}) begin
         errors++; $display("FAIL async_abort: got busy=%b done=%b z_dout=%h expected 0 0 0", busy, done, z_dout);
      end
      @(posedge clock); #1 reset = 1'b1;
      tick();
      run_mat(8, 1'b0, 1'b0, 1'b0, 0, 0, "after_abort");
      check_z("after_abort");
   endtask

   initial begin
      test_reset();
      test_identity();
      test_partial_tile();
      test_accumulate();
      test_illegal();
      test_wrap_and_drop();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/matmul_lanes.md
Name: matmul_lanes

Overview:
Runtime-sized, lane-parallel successor to the fixed-size matrix multiply top. Computes Z = X·Y, or Z += X·Y in accumulate mode, for square n×n signed integer matrices with n ≤ MAX_SIZE. It holds its own X/Y/Z storage, which the host loads and reads through simple RAM-style ports. LANES MAC units compute LANES adjacent Z columns per pass.

Parameters:
DATA_WIDTH, 32, element width; signed two's complement
ADDR_WIDTH, 10, host address width; must satisfy 2^ADDR_WIDTH ≥ MAX_SIZE²
MAX_SIZE, 8, largest supported n; row stride of all three matrices
LANES, 2, parallel MAC lanes; must divide MAX_SIZE; Y and Z are banked by column mod LANES

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled in IDLE only
size  in  $clog2(MAX_SIZE)+1  runtime n; sampled with start
accumulate  in  1  0: Z=X·Y, 1: Z+=X·Y; sampled with start
busy  out  1  high from accepted start until the done pulse
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse on an illegal start or a dropped host write
x_wr_en / x_wr_addr / x_din  in  1 / ADDR_WIDTH / DATA_WIDTH  X write port
y_wr_en / y_wr_addr / y_din  in  1 / ADDR_WIDTH / DATA_WIDTH  Y write port
z_rd_addr  in  ADDR_WIDTH  Z read address
z_dout  out  DATA_WIDTH  Z read data, 1-cycle registered latency

Behaviour:
- Addressing: element (r,c) lives at r*MAX_SIZE+c for every n. Cells with r≥n or c≥n are never read or written by a run.
- Reset (reset=0, async): FSM→IDLE; busy, done, err, z_dout = 0. Matrix storage is not cleared.
- Host writes: accepted when busy=0. While busy=1 the write is dropped and err pulses the following cycle.
- Z reads: z_dout updates the cycle after z_rd_addr is presented when busy=0. While busy=1, z_dout holds its last value.
- IDLE: on start=1, legal iff 1 ≤ size ≤ MAX_SIZE and size mod LANES = 0.
  - Legal: latch n and accumulate, busy=1 next cycle, → ISSUE with i=0, j0=0, k=0.
  - Illegal: err pulses 1 cycle, stay IDLE, no done.
  - start while busy is ignored, with no err.
- ISSUE (n cycles): each cycle read X[i][k] and Y[k][j0+l] for l=0..LANES-1, then k++. On the first cycle also read Z[i][j0+l] when accumulate=1.
- DRAIN (1 cycle): final read data enters the MACs.
- WB (1 cycle): write acc_l, or Zold_l+acc_l, to Z[i][j0+l] for all lanes. Then:
  - if j0+LANES<n: j0+=LANES;
  - else j0=0 and i++;
  - → ISSUE, or → FIN after the last tile.
- FIN: done=1 and busy=0 in the same cycle → IDLE.
- Timing: start-accept edge to done pulse = 1 + (n·n/LANES)·(n+2) cycles. A new start is accepted the cycle after done.
- Arithmetic: product = low DATA_WIDTH bits of the signed multiply. The accumulator wraps mod 2^DATA_WIDTH with no saturation and no overflow flag. Accumulators clear at each tile start.
- Simultaneous start and host write in IDLE: the write lands; the run sees the new data.
- Reset mid-run: abort immediately. Z holds partial results; the next run is unaffected apart from accumulate reading those partials.

Test Plan:
1. MAX_SIZE=8, LANES=2, n=8, X=identity, Y[r][c]=r*8+c, accumulate=0 → Z=Y at all 64 addresses; done exactly 321 cycles after start accept; busy high throughout.
2. n=4, X all 2, Y all 3, Z preloaded 0xDEADBEEF → Z[i][j]=24 at i*8+j for i,j<4; every other Z cell still 0xDEADBEEF.
3. Rerun of scenario 2 with accumulate=1 → Z[i][j]=48 for i,j<4; done after 1+8·6=49 cycles.
4. start with size=3, then size=0, then size=9 → each gives one err pulse; busy and done stay 0; Z unchanged.
5. n=2, X all 0x7FFFFFFF, Y all 2 → every Z[i][j]=0xFFFFFFFC (wrap); x_wr_en pulsed during the run → err pulse, X unchanged.
6. Reset driven low 50 cycles into an n=8 run → busy, done, z_dout = 0 asynchronously; a fresh n=8 identity run afterwards matches scenario 1 with the same latency.
